// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent programmable timers on a word-addressed register bus.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   we, addr, wdata   - register write port; addr = {channel, offset[1:0]}
//   rdata             - combinational read data for addr
//   timer_int_ack     - per-channel acknowledge, clears the pending bit
//   timer_int         - per-channel pending interrupt (registered)
//   irq               - OR of all timer_int bits
// Register offsets: 0 CTRL {PRESCALE[8+:PS_W], PERIODIC, EN}, 1 LIMIT, 2 COUNT, 3 STATUS {OVR, PEND} (W1C).
module timer_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PS_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(NUM_CH)+1:0]  addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  input  logic [NUM_CH-1:0]          timer_int_ack,
  output logic [NUM_CH-1:0]          timer_int,
  output logic                       irq
);

  localparam int unsigned ADDR_W = $clog2(NUM_CH) + 2;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] sel_ch;
  logic [1:0]      sel_off;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] per_q, per_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [PS_W-1:0]   ps_q    [NUM_CH];
  logic [PS_W-1:0]   ps_d    [NUM_CH];
  logic [PS_W-1:0]   pcnt_q  [NUM_CH];
  logic [PS_W-1:0]   pcnt_d  [NUM_CH];
  logic [CNT_W-1:0]  limit_q [NUM_CH];
  logic [CNT_W-1:0]  limit_d [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];

  logic [NUM_CH-1:0] wr_ctrl, wr_limit, wr_count, wr_status;
  logic [NUM_CH-1:0] tick, expire, pend_clr;

  assign sel_off = addr[1:0];

  // Channel field is absent when there is only one channel.
  generate
    if (NUM_CH > 1) begin : g_ch_multi
      assign sel_ch = addr[ADDR_W-1:2];
    end else begin : g_ch_single
      assign sel_ch = '0;
    end
  endgenerate

  // Write decode per channel and offset.
  always_comb begin
    wr_ctrl   = '0;
    wr_limit  = '0;
    wr_count  = '0;
    wr_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (we && (sel_ch == CH_W'(c))) begin
        case (sel_off)
          2'd0:    wr_ctrl[c]   = 1'b1;
          2'd1:    wr_limit[c]  = 1'b1;
          2'd2:    wr_count[c]  = 1'b1;
          default: wr_status[c] = 1'b1;
        endcase
      end
    end
  end

  // Tick/expiry qualification; a CTRL or COUNT write discards a coincident tick.
  always_comb begin
    tick     = '0;
    expire   = '0;
    pend_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick[c]     = en_q[c] && (pcnt_q[c] == ps_q[c]) && !wr_ctrl[c] && !wr_count[c];
      expire[c]   = tick[c] && (limit_q[c] != '0) && (count_q[c] >= (limit_q[c] - CNT_W'(1)));
      pend_clr[c] = timer_int_ack[c] || (wr_status[c] && wdata[0]);
    end
  end

  // Next-state for every channel.
  always_comb begin
    en_d   = en_q;
    per_d  = per_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      ps_d[c]    = ps_q[c];
      pcnt_d[c]  = pcnt_q[c];
      limit_d[c] = limit_q[c];
      count_d[c] = count_q[c];

      if (wr_ctrl[c]) begin
        en_d[c]  = wdata[0];
        per_d[c] = wdata[1];
        ps_d[c]  = wdata[8 +: PS_W];
      end else if (expire[c] && !per_q[c]) begin
        en_d[c] = 1'b0;
      end

      if (wr_limit[c]) begin
        limit_d[c] = wdata[CNT_W-1:0];
      end

      if (wr_ctrl[c] || wr_count[c] || !en_q[c] || tick[c]) begin
        pcnt_d[c] = '0;
      end else begin
        pcnt_d[c] = pcnt_q[c] + PS_W'(1);
      end

      if (wr_count[c]) begin
        count_d[c] = wdata[CNT_W-1:0];
      end else if (expire[c]) begin
        count_d[c] = '0;
      end else if (tick[c] && (limit_q[c] != '0)) begin
        count_d[c] = count_q[c] + CNT_W'(1);
      end

      // A new expiry beats any clear; overrun only when an uncleared event is lost.
      if (expire[c]) begin
        pend_d[c] = 1'b1;
      end else if (pend_clr[c]) begin
        pend_d[c] = 1'b0;
      end

      if (expire[c] && pend_q[c] && !pend_clr[c]) begin
        ovr_d[c] = 1'b1;
      end else if (wr_status[c] && wdata[1]) begin
        ovr_d[c] = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      per_q  <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ps_q[c]    <= '0;
        pcnt_q[c]  <= '0;
        limit_q[c] <= '0;
        count_q[c] <= '0;
      end
    end else begin
      en_q   <= en_d;
      per_q  <= per_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        ps_q[c]    <= ps_d[c];
        pcnt_q[c]  <= pcnt_d[c];
        limit_q[c] <= limit_d[c];
        count_q[c] <= count_d[c];
      end
    end
  end

  // Read mux; unimplemented bits and out-of-range channels read as zero.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == CH_W'(c)) begin
        case (sel_off)
          2'd0:    rdata = 32'({ps_q[c], 6'b0, per_q[c], en_q[c]});
          2'd1:    rdata = 32'(limit_q[c]);
          2'd2:    rdata = 32'(count_q[c]);
          default: rdata = 32'({ovr_q[c], pend_q[c]});
        endcase
      end
    end
  end

  assign timer_int = pend_q;
  assign irq       = |pend_q;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int K_RD  = 0;
  localparam int K_INT = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] exp;
    logic [3:0]  a;
    string       name;
  } sb_item_t;

  logic              clk;
  logic              reset;
  logic              we;
  logic [3:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] timer_int_ack;
  logic [NUM_CH-1:0] timer_int;
  logic              irq;

  int unsigned cyc;
  int          checks;
  int          errors;
  sb_item_t    sb [$];
  sb_item_t    e;
  logic [31:0] act;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(32), .PS_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .timer_int_ack (timer_int_ack),
    .timer_int     (timer_int),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every scoreboard entry due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        e = sb[i];
        sb.delete(i);
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else begin
          case (e.kind)
            K_RD:    act = rdata;
            K_INT:   act = 32'(timer_int);
            default: act = 32'(irq);
          endcase
          if (e.kind == K_RD && addr !== e.a) begin
            errors++;
            $display("FAIL %s: bus addr %0h, required %0h at cycle %0d", e.name, addr, e.a, cyc);
          end else if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at cycle %0d", e.name, act, e.exp, cyc);
          end
        end
      end
    end
  end

  task automatic push(input int unsigned at, input int kind, input logic [31:0] v,
                      input logic [3:0] a, input string name);
    sb_item_t it;
    it.cyc  = at;
    it.kind = kind;
    it.exp  = v;
    it.a    = a;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic exp_int(input int unsigned at, input logic [3:0] v, input string name);
    push(at, K_INT, 32'(v), 4'h0, name);
  endtask

  task automatic exp_irq(input int unsigned at, input logic v, input string name);
    push(at, K_IRQ, 32'(v), 4'h0, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] v, input string name);
    addr = a;
    push(cyc, K_RD, v, a, name);
    step();
  endtask

  task automatic ack(input logic [3:0] m);
    timer_int_ack = m;
    step();
    timer_int_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t0;
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    we            = 1'b0;
    addr          = '0;
    wdata         = '0;
    timer_int_ack = '0;
    step();
    step();

    // Reset state.
    exp_int(cyc, 4'b0000, "rst_int");
    exp_irq(cyc, 1'b0, "rst_irq");
    rd(4'd0, 32'h0, "rst_ctrl0");
    rd(4'd1, 32'h0, "rst_limit0");
    reset = 1'b0;
    step();

    // Ch0 periodic LIMIT=5: fires 5 cycles after the enabling edge, COUNT cycles 0..4.
    wr(4'd1, 32'd5);
    wr(4'd0, 32'h3);
    t0 = cyc;
    exp_int(t0 + 4, 4'b0000, "p5_pre");
    exp_int(t0 + 5, 4'b0001, "p5_first");
    exp_irq(t0 + 5, 1'b1, "p5_irq");
    exp_int(t0 + 7, 4'b0000, "p5_acked");
    exp_int(t0 + 9, 4'b0000, "p5_pre2");
    exp_int(t0 + 10, 4'b0001, "p5_second");
    rd(4'd2, 32'd0, "p5_cnt0");
    rd(4'd2, 32'd1, "p5_cnt1");
    rd(4'd2, 32'd2, "p5_cnt2");
    rd(4'd2, 32'd3, "p5_cnt3");
    rd(4'd2, 32'd4, "p5_cnt4");
    rd(4'd2, 32'd0, "p5_cntwrap");
    ack(4'b0001);
    wait_until(t0 + 10);
    wr(4'd0, 32'h0);
    wr(4'd3, 32'h3);
    rd(4'd3, 32'h0, "p5_status_clr");
    rd(4'd0, 32'h0, "p5_ctrl_off");

    // Ch1 one-shot LIMIT=3.
    wr(4'd5, 32'd3);
    wr(4'd4, 32'h1);
    t0 = cyc;
    exp_int(t0 + 2, 4'b0000, "os_pre");
    exp_int(t0 + 3, 4'b0010, "os_fire");
    exp_int(t0 + 6, 4'b0000, "os_quiet6");
    exp_int(t0 + 15, 4'b0000, "os_quiet15");
    exp_int(t0 + 25, 4'b0000, "os_quiet25");
    wait_until(t0 + 4);
    ack(4'b0010);
    rd(4'd4, 32'h0, "os_ctrl");
    rd(4'd6, 32'h0, "os_count");
    rd(4'd7, 32'h0, "os_status");
    wait_until(t0 + 26);

    // Ch2 LIMIT=2 PRESCALE=3: period 8; COUNT write of 1 expires 4 cycles later.
    wr(4'd9, 32'd2);
    wr(4'd8, 32'h303);
    t0 = cyc;
    exp_int(t0 + 7, 4'b0000, "ps_pre");
    exp_int(t0 + 8, 4'b0100, "ps_fire1");
    exp_int(t0 + 9, 4'b0000, "ps_ack1");
    exp_int(t0 + 15, 4'b0000, "ps_pre2");
    exp_int(t0 + 16, 4'b0100, "ps_fire2");
    exp_int(t0 + 17, 4'b0000, "ps_ack2");
    rd(4'd8, 32'h303, "ps_ctrl");
    wait_until(t0 + 8);
    ack(4'b0100);
    wait_until(t0 + 16);
    ack(4'b0100);
    wait_until(t0 + 18);
    wr(4'd10, 32'd1);
    t0 = cyc;
    exp_int(t0 + 3, 4'b0000, "ps_cw_pre");
    exp_int(t0 + 4, 4'b0100, "ps_cw_fire");
    rd(4'd10, 32'd1, "ps_cw_count");
    wait_until(t0 + 4);
    rd(4'd11, 32'h1, "ps_cw_status");
    wr(4'd8, 32'h0);
    wr(4'd11, 32'h3);
    exp_int(cyc, 4'b0000, "ps_cleared");
    step();

    // Ch0 LIMIT=4: overrun, OVR-only W1C, ack coinciding with expiry.
    wr(4'd1, 32'd4);
    wr(4'd0, 32'h3);
    t0 = cyc;
    exp_int(t0 + 3, 4'b0000, "ov_pre");
    exp_int(t0 + 4, 4'b0001, "ov_fire");
    exp_int(t0 + 12, 4'b0001, "ov_ack_same");
    wait_until(t0 + 8);
    rd(4'd3, 32'h3, "ov_status_both");
    wr(4'd3, 32'h2);
    rd(4'd3, 32'h1, "ov_w1c_ovr");
    ack(4'b0001);
    rd(4'd3, 32'h1, "ov_ack_expiry");

    // Ch3 LIMIT=100, reset in the middle of the count.
    wr(4'd13, 32'd100);
    wr(4'd12, 32'h3);
    t0 = cyc;
    wait_until(t0 + 49);
    rd(4'd14, 32'd49, "rm_count49");
    reset = 1'b1;
    exp_int(cyc, 4'b0000, "rm_int");
    exp_irq(cyc, 1'b0, "rm_irq");
    rd(4'd14, 32'h0, "rm_count");
    rd(4'd12, 32'h0, "rm_ctrl3");
    rd(4'd13, 32'h0, "rm_limit3");
    rd(4'd1, 32'h0, "rm_limit0");
    rd(4'd3, 32'h0, "rm_status0");
    reset = 1'b0;
    t0 = cyc;
    exp_int(t0 + 1, 4'b0000, "rm_after1");
    exp_int(t0 + 101, 4'b0000, "rm_after101");
    exp_irq(t0 + 101, 1'b0, "rm_irq_after");
    wait_until(t0 + 102);

    // Ch0 LIMIT=3 and ch3 LIMIT=7 concurrently, then shrink ch3 LIMIT.
    wr(4'd1, 32'd3);
    wr(4'd13, 32'd7);
    wr(4'd0, 32'h3);
    t0 = cyc;
    wr(4'd12, 32'h3);
    exp_int(t0 + 2, 4'b0000, "ind_pre");
    exp_irq(t0 + 2, 1'b0, "ind_irq_pre");
    exp_int(t0 + 3, 4'b0001, "ind_ch0");
    exp_irq(t0 + 3, 1'b1, "ind_irq_ch0");
    exp_int(t0 + 7, 4'b0001, "ind_ch3_pre");
    exp_int(t0 + 8, 4'b1001, "ind_both");
    exp_int(t0 + 10, 4'b1000, "ind_ack0");
    exp_int(t0 + 11, 4'b0000, "ind_ack3");
    exp_irq(t0 + 11, 1'b0, "ind_irq_none");
    exp_int(t0 + 12, 4'b0001, "ind_ch0_again");
    exp_irq(t0 + 12, 1'b1, "ind_irq_again");
    exp_int(t0 + 13, 4'b0001, "shr_pre");
    exp_int(t0 + 14, 4'b1001, "shr_fire");
    wait_until(t0 + 9);
    ack(4'b0001);
    ack(4'b1000);
    wait_until(t0 + 12);
    wr(4'd13, 32'd2);
    rd(4'd14, 32'd5, "shr_count5");
    rd(4'd14, 32'd0, "shr_count0");

    // Drain any outstanding expectations (bounded).
    for (int i = 0; i < 200 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
Parametrised multi-channel timer that succeeds the single fixed-limit interrupt timer. It holds NUM_CH independent channels. Each channel has a programmable limit, a prescaler, periodic or one-shot mode, a sticky pending interrupt with acknowledge, and overrun detection. The block sits on the CPU data-memory bus as a word-addressed register slave and drives per-channel interrupt lines plus a combined irq into the interrupt/CSR logic.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
CNT_W, 32, counter/limit width (1..32); zero-extended onto rdata
PS_W, 8, prescaler width (1..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
we  input  1  register write strobe, one write per cycle
addr  input  $clog2(NUM_CH)+2  word address: {channel, offset[1:0]}
wdata  input  32  write data
rdata  output  32  combinational read data for addr
timer_int_ack  input  NUM_CH  per-channel acknowledge, clears pending
timer_int  output  NUM_CH  per-channel pending interrupt (registered)
irq  output  1  OR of all timer_int bits

Behaviour:
- Register map, per channel c, offset:
  - 0 CTRL: bit0 EN, bit1 PERIODIC (1 = periodic, 0 = one-shot), bits[8+PS_W-1:8] PRESCALE.
  - 1 LIMIT: CNT_W bits.
  - 2 COUNT: read current count; a write loads it.
  - 3 STATUS: bit0 PEND, bit1 OVR; write-1-to-clear.
  - Unused read bits return 0.
- Reset: all CTRL/LIMIT/COUNT/STATUS, prescaler counters, timer_int, and irq go to 0. Reset mid-count aborts immediately with no interrupt.
- Prescaler: per-channel pcnt increments each cycle while EN=1. When pcnt == PRESCALE it generates a tick and pcnt goes to 0. Tick period is PRESCALE+1 cycles; PRESCALE=0 ticks every cycle. pcnt holds at 0 while EN=0.
- Count, on a tick with LIMIT != 0:
  - If COUNT >= LIMIT-1, the channel expires: COUNT goes to 0.
  - Otherwise COUNT increments by 1.
  - The >= comparison means a limit shrunk below the current count expires on the next tick.
  - LIMIT=0: the channel never expires and COUNT holds.
- Expiry effects, at the same edge as the expiring tick:
  - PEND is set. If PEND was already 1 and is not being cleared this cycle, OVR is set instead.
  - In one-shot mode EN is cleared.
- Latency: with PRESCALE=0 and LIMIT=L, EN written at edge 0 gives timer_int high after edge L, then every L cycles in periodic mode.
- PEND clear sources: timer_int_ack[c], or a STATUS write with bit0=1. OVR clears only via a STATUS write with bit1=1.
- Simultaneous events:
  - Expiry together with ack or W1C: PEND stays 1 (new event wins) and OVR is not set.
  - Write to COUNT or CTRL in the same cycle as a tick: the write wins, the tick is discarded, and pcnt resets to 0.
  - A CTRL write setting EN=1 in the cycle a one-shot expires: the write wins and the channel stays enabled.
- Writes to CTRL and COUNT reset that channel's pcnt to 0. LIMIT writes do not touch pcnt or COUNT.
- Width rules: wdata is truncated to CNT_W or PS_W. Count arithmetic is modulo 2^CNT_W but never wraps, because expiry bounds it.
- Channels are fully independent. irq = |timer_int.

Test Plan:
- Ch0: LIMIT=5, CTRL=0x3 (EN, periodic, PS=0) -> timer_int[0] rises exactly 5 cycles after the write edge; after ack it re-asserts every 5 cycles; COUNT reads 0..4 cyclically.
- Ch1: LIMIT=3, CTRL=0x1 (one-shot) -> single interrupt after 3 cycles; CTRL reads 0x0 afterwards; COUNT=0; no further interrupts over 20 cycles.
- Ch2: LIMIT=2, PRESCALE=3 (CTRL=0x303) -> interrupt every 8 cycles; a COUNT write of 1 mid-period -> expiry 4 cycles after the write.
- Ch0: LIMIT=4, no ack across two expiries -> STATUS=0x3. A STATUS write of 0x2 -> STATUS=0x1. Ack asserted in the exact expiry cycle -> PEND stays 1, OVR stays 0.
- Ch3: LIMIT=100, assert reset at count 50 -> all outputs and registers read 0 in the same cycle; no interrupt after reset release.
- Ch0 and ch3 running with LIMIT=3 and LIMIT=7 -> independent timer_int bits; irq equals their OR; a LIMIT write of 2 while ch3 COUNT=5 -> ch3 expires on the next tick.
